// File: rtl/counter_checker.sv
// Checks that an observed free-running up/down counter steps by exactly one each cycle.
// Optional mismatch capture registers are enabled with COUNTER_CHECKER_CAPTURE_EN.
module counter_checker #(
    parameter int WIDTH     = 10,
    parameter int ERR_CNT_W = 8,
    parameter int LOCK_CNT  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     cnt_in,
    output logic                 locked,
    output logic                 err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count
`ifdef COUNTER_CHECKER_CAPTURE_EN
    ,
    output logic                 cap_valid,
    output logic [WIDTH-1:0]     cap_expected,
    output logic [WIDTH-1:0]     cap_observed
`endif
);

    localparam logic [1:0] SYNC    = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;
    localparam logic [1:0] RESYNC  = 2'd3;

    localparam int MCW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

    logic [1:0]       state, state_nxt;
    logic [MCW-1:0]   match_cnt, match_nxt;
    logic [WIDTH-1:0] prev_cnt, expected;
    logic             prev_mode;
    logic             hit, locked_miss;

    always_comb begin
        // Unsigned arithmetic wraps naturally at 2^WIDTH, so counter wrap is a legal step.
        expected    = prev_mode ? prev_cnt + WIDTH'(1) : prev_cnt - WIDTH'(1);
        hit         = (cnt_in == expected);
        locked_miss = (state == LOCKED) && !hit;
        state_nxt   = state;
        match_nxt   = match_cnt;
        case (state)
            SYNC: begin
                state_nxt = ACQUIRE;
                match_nxt = '0;
            end
            ACQUIRE, RESYNC: begin
                if (!hit) begin
                    match_nxt = '0;
                end else if (match_cnt + MCW'(1) >= MCW'(LOCK_CNT)) begin
                    state_nxt = LOCKED;
                    match_nxt = '0;
                end else begin
                    match_nxt = match_cnt + MCW'(1);
                end
            end
            LOCKED: begin
                if (!hit) begin
                    state_nxt = RESYNC;
                    match_nxt = '0;
                end
            end
            default: begin
                state_nxt = SYNC;
                match_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SYNC;
            match_cnt  <= '0;
            prev_cnt   <= '0;
            prev_mode  <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_nxt;
            match_cnt  <= match_nxt;
            prev_cnt   <= cnt_in;
            prev_mode  <= mode;
            locked     <= (state_nxt == LOCKED);
            err        <= locked_miss;
            if (locked_miss) begin
                err_sticky <= 1'b1;
                if (err_count != {ERR_CNT_W{1'b1}})
                    err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

`ifdef COUNTER_CHECKER_CAPTURE_EN
    // Only the first locked mismatch after reset is kept; later ones leave it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_valid    <= 1'b0;
            cap_expected <= '0;
            cap_observed <= '0;
        end else if (locked_miss && !cap_valid) begin
            cap_valid    <= 1'b1;
            cap_expected <= expected;
            cap_observed <= cnt_in;
        end
    end
`endif

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker: lock, wrap, mode turn, error/relock, saturation, reset priority.
// Capture outputs are checked only when COUNTER_CHECKER_CAPTURE_EN is defined.
module tb_counter_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0;
    logic [9:0] cnt_in = '0;
    logic       locked, err, err_sticky;
    logic [7:0] err_count;
`ifdef COUNTER_CHECKER_CAPTURE_EN
    logic       cap_valid;
    logic [9:0] cap_expected, cap_observed;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    counter_checker dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .cnt_in     (cnt_in),
        .locked     (locked),
        .err        (err),
        .err_sticky (err_sticky),
        .err_count  (err_count)
`ifdef COUNTER_CHECKER_CAPTURE_EN
        ,
        .cap_valid    (cap_valid),
        .cap_expected (cap_expected),
        .cap_observed (cap_observed)
`endif
    );

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // Apply one sample; outputs are read 1 time unit after the edge that took it.
    task automatic cyc(input logic m, input logic [9:0] c);
        mode   = m;
        cnt_in = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         nerr;
        int         exp_cnt;
        logic [9:0] v;

        // reset for two cycles
        cyc(1'b0, 10'd0);
        cyc(1'b0, 10'd0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        chk("rst_sticky", err_sticky, 0);
        chk("rst_count", err_count, 0);
        rst = 1'b0;

        // acquire: sample 0 is SYNC, 1 and 2 are the two matches
        cyc(1'b1, 10'd0);
        chk("sync_locked", locked, 0);
        cyc(1'b1, 10'd1);
        chk("acq1_locked", locked, 0);
        cyc(1'b1, 10'd2);
        chk("acq2_locked", locked, 1);
        chk("acq2_err", err, 0);
        cyc(1'b1, 10'd3);
        cyc(1'b1, 10'd4);
        chk("run_locked", locked, 1);
        chk("run_count", err_count, 0);

        // count up to the top and wrap
        nerr = 0;
        for (int i = 5; i <= 1023; i++) begin
            cyc(1'b1, 10'(i));
            nerr += int'(err);
        end
        cyc(1'b1, 10'd0);
        nerr += int'(err);
        cyc(1'b1, 10'd1);
        nerr += int'(err);
        chk("wrap_up_errs", nerr, 0);
        chk("wrap_up_locked", locked, 1);

        // mode turns down on the sample that still shows the last up step
        nerr = 0;
        cyc(1'b0, 10'd2);
        nerr += int'(err);
        cyc(1'b0, 10'd1);
        nerr += int'(err);
        cyc(1'b0, 10'd0);
        nerr += int'(err);
        cyc(1'b0, 10'd1023);
        nerr += int'(err);
        chk("wrap_dn_errs", nerr, 0);
        chk("wrap_dn_locked", locked, 1);
        chk("wrap_dn_sticky", err_sticky, 0);

        // reset mid-run, relock up to 5
        rst = 1'b1;
        cyc(1'b1, 10'd0);
        rst = 1'b0;
        for (int i = 0; i <= 5; i++) cyc(1'b1, 10'(i));
        chk("relock5_locked", locked, 1);

        // inject 9 instead of 6
        cyc(1'b1, 10'd9);
        chk("inj_err", err, 1);
        chk("inj_locked", locked, 0);
        chk("inj_sticky", err_sticky, 1);
        chk("inj_count", err_count, 1);
`ifdef COUNTER_CHECKER_CAPTURE_EN
        chk("inj_cap_valid", cap_valid, 1);
        chk("inj_cap_exp", cap_expected, 6);
        chk("inj_cap_obs", cap_observed, 9);
`endif
        cyc(1'b1, 10'd10);
        chk("rs1_err", err, 0);
        chk("rs1_locked", locked, 0);
        cyc(1'b1, 10'd11);
        chk("rs2_locked", locked, 1);
        chk("rs2_err", err, 0);
        cyc(1'b1, 10'd12);
        chk("rs3_err", err, 0);
        chk("rs3_count", err_count, 1);
        chk("rs3_sticky", err_sticky, 1);
`ifdef COUNTER_CHECKER_CAPTURE_EN
        chk("rs3_cap_exp", cap_expected, 6);
        chk("rs3_cap_obs", cap_observed, 9);
`endif

        // 300 locked mismatches, each followed by a two-sample relock
        v       = 10'd12;
        exp_cnt = 1;
        nerr    = 0;
        for (int k = 1; k <= 300; k++) begin
            cyc(1'b1, v + 10'd5);
            if (!err) nerr++;
            cyc(1'b1, v + 10'd6);
            cyc(1'b1, v + 10'd7);
            if (!locked) nerr++;
            v = v + 10'd7;
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            if (k == 200) chk("sat_mid_count", err_count, exp_cnt);
        end
        chk("sat_round_misses", nerr, 0);
        chk("sat_count", err_count, 255);
`ifdef COUNTER_CHECKER_CAPTURE_EN
        chk("sat_cap_obs", cap_observed, 9);
`endif

        // reset coincident with a locked mismatch
        chk("pre_rst_locked", locked, 1);
        rst = 1'b1;
        cyc(1'b1, v + 10'd5);
        chk("rstmiss_err", err, 0);
        chk("rstmiss_locked", locked, 0);
        chk("rstmiss_sticky", err_sticky, 0);
        chk("rstmiss_count", err_count, 0);
`ifdef COUNTER_CHECKER_CAPTURE_EN
        chk("rstmiss_cap_valid", cap_valid, 0);
        chk("rstmiss_cap_exp", cap_expected, 0);
`endif
        rst = 1'b0;
        cyc(1'b1, 10'd100);
        chk("post_rst_err", err, 0);
        chk("post_rst_locked", locked, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
